cdb_arbiter: RTL

- Producer side of the common data bus consumed by the reservation station, ROB and register file.
- Collects completed results from the functional units (alu, mul, div, br) and buffers each source in a small per-source FIFO.
- Arbitrates round-robin among sources onto CDB_SIZE broadcast lanes.
- Drives registered CDB outputs that wake up waiting reservation-station entries.

---
 rtl/cdb_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding a round-robin arbiter onto CDB_SIZE registered broadcast lanes.
// Ready depends only on FIFO occupancy; winners pop their head and are broadcast the following cycle.
module cdb_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int CDB_SIZE   = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int PREG_W     = 6,
   parameter int ROB_W      = 4,
   parameter int XLEN       = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic [NUM_SRC-1:0]                 src_valid,
   output logic [NUM_SRC-1:0]                 src_ready,
   input  logic [NUM_SRC-1:0][PREG_W-1:0]     src_paddr,
   input  logic [NUM_SRC-1:0][ROB_W-1:0]      src_rob,
   input  logic [NUM_SRC-1:0][XLEN-1:0]       src_data,
   output logic [CDB_SIZE-1:0]                cdb_valid,
   output logic [CDB_SIZE-1:0][PREG_W-1:0]    cdb_paddr,
   output logic [CDB_SIZE-1:0][ROB_W-1:0]     cdb_rob,
   output logic [CDB_SIZE-1:0][XLEN-1:0]      cdb_data
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int LW = (CDB_SIZE > 1) ? $clog2(CDB_SIZE) : 1;
   localparam int EW = PREG_W + ROB_W + XLEN;

   typedef logic [EW-1:0] ent_t;

   ent_t                              mem_q [NUM_SRC][FIFO_DEPTH];
   ent_t                              head [NUM_SRC];
   logic [AW-1:0]                     wr_q [NUM_SRC];
   logic [AW-1:0]                     rd_q [NUM_SRC];
   logic [CW-1:0]                     cnt_q [NUM_SRC];
   logic [SW-1:0]                     rr_q, rr_d;
   logic [SW-1:0]                     idx;
   logic [SW-1:0]                     lane_src [CDB_SIZE];
   logic [CDB_SIZE-1:0]               lane_v;
   logic [NUM_SRC-1:0]                push, pop;
   logic [CDB_SIZE-1:0]               cdb_valid_q;
   logic [CDB_SIZE-1:0][PREG_W-1:0]   cdb_paddr_q;
   logic [CDB_SIZE-1:0][ROB_W-1:0]    cdb_rob_q;
   logic [CDB_SIZE-1:0][XLEN-1:0]     cdb_data_q;
   int                                n;

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = cnt_q[i] < CW'(FIFO_DEPTH);
         head[i]      = mem_q[i][rd_q[i]];
      end
   end

   assign push = src_valid & src_ready & {NUM_SRC{~flush}};

   // Scan from rr_q; the k-th non-empty source found takes lane k.
   always_comb begin
      pop      = '0;
      lane_v   = '0;
      lane_src = '{default: '0};
      rr_d     = rr_q;
      idx      = '0;
      n        = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = SW'((int'(rr_q) + k) % NUM_SRC);
         if (cnt_q[idx] != '0 && n < CDB_SIZE) begin
            pop[idx]          = 1'b1;
            lane_v[LW'(n)]    = 1'b1;
            lane_src[LW'(n)]  = idx;
            rr_d              = SW'((int'(idx) + 1) % NUM_SRC);
            n                 = n + 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++)
         if (push[i]) mem_q[i][wr_q[i]] <= {src_paddr[i], src_rob[i], src_data[i]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q        <= '0;
         cdb_valid_q <= '0;
         cdb_paddr_q <= '0;
         cdb_rob_q   <= '0;
         cdb_data_q  <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_q[i]  <= '0;
            rd_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else if (flush) begin
         rr_q        <= '0;
         cdb_valid_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_q[i]  <= '0;
            rd_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         rr_q        <= rr_d;
         cdb_valid_q <= lane_v;
         for (int i = 0; i < NUM_SRC; i++) begin
            wr_q[i]  <= wr_q[i] + AW'(push[i]);
            rd_q[i]  <= rd_q[i] + AW'(pop[i]);
            cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         end
         for (int j = 0; j < CDB_SIZE; j++)
            if (lane_v[j]) {cdb_paddr_q[j], cdb_rob_q[j], cdb_data_q[j]} <= head[lane_src[j]];
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_paddr = cdb_paddr_q;
   assign cdb_rob   = cdb_rob_q;
   assign cdb_data  = cdb_data_q;
endmodule
